// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready stall
//
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready, in1, in2, cin, sub : operand beat (sub=1 -> in1-in2, cin ignored)
//   out_valid/out_ready, sum, cout, ovf   : result beat (cout = inverted borrow when sub=1)
//   P, G                                  : 4-bit group propagate/generate of the result beat
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               cin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               cout,
  output logic               ovf,
  output logic [WIDTH/4-1:0] P,
  output logic [WIDTH/4-1:0] G
);

  localparam int SW = WIDTH / STAGES;  // bits per slice
  localparam int SG = SW / 4;          // 4-bit groups per slice
  localparam int NG = WIDTH / 4;       // groups in the whole word

  // Pipeline stage s: index 0 is the input register, index s holds slices 0..s-1 computed.
  // a/b keep the not-yet-computed operand bits, s keeps computed sum bits.
  logic             valid_q [0:STAGES];
  logic             valid_d [0:STAGES];
  logic [WIDTH-1:0] a_q     [0:STAGES];
  logic [WIDTH-1:0] a_d     [0:STAGES];
  logic [WIDTH-1:0] b_q     [0:STAGES];
  logic [WIDTH-1:0] b_d     [0:STAGES];
  logic [WIDTH-1:0] s_q     [0:STAGES];
  logic [WIDTH-1:0] s_d     [0:STAGES];
  logic [NG-1:0]    p_q     [0:STAGES];
  logic [NG-1:0]    p_d     [0:STAGES];
  logic [NG-1:0]    g_q     [0:STAGES];
  logic [NG-1:0]    g_d     [0:STAGES];
  logic             c_q     [0:STAGES];  // carry into the next uncomputed slice
  logic             c_d     [0:STAGES];
  logic             cm_q    [0:STAGES];  // carry into the MSB, valid once the top slice is done
  logic             cm_d    [0:STAGES];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [NG-1:0]    pg_q, pg_d;
  logic [NG-1:0]    gg_q, gg_d;

  logic             en;
  logic [6:0]       r;
  logic             c;

  // One 4-bit lookahead group: returns {carry into bit 3, G, P, sum[3:0]}.
  function automatic logic [6:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] p;
    logic [3:0] g;
    logic       c1, c2, c3, gg, pg;
    p  = a ^ b;
    g  = a & b;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg = &p;
    return {c3, gg, pg, p ^ {c3, c2, c1, ci}};
  endfunction

  // Whole pipeline advances together; a stalled output freezes everything.
  assign en       = !out_valid_q | out_ready;
  assign in_ready = en;

  always_comb begin
    r = '0;
    c = 1'b0;
    for (int s = 0; s <= STAGES; s++) begin
      valid_d[s] = valid_q[s];
      a_d[s]     = a_q[s];
      b_d[s]     = b_q[s];
      s_d[s]     = s_q[s];
      p_d[s]     = p_q[s];
      g_d[s]     = g_q[s];
      c_d[s]     = c_q[s];
      cm_d[s]    = cm_q[s];
    end
    if (en) begin
      valid_d[0] = in_valid;
      a_d[0]     = in1;
      b_d[0]     = in2 ^ {WIDTH{sub}};
      c_d[0]     = sub | cin;
      s_d[0]     = '0;
      p_d[0]     = '0;
      g_d[0]     = '0;
      cm_d[0]    = 1'b0;
      for (int s = 1; s <= STAGES; s++) begin
        valid_d[s] = valid_q[s-1];
        a_d[s]     = a_q[s-1];
        b_d[s]     = b_q[s-1];
        s_d[s]     = s_q[s-1];
        p_d[s]     = p_q[s-1];
        g_d[s]     = g_q[s-1];
        cm_d[s]    = cm_q[s-1];
        c          = c_q[s-1];
        // Groups inside a slice chain through their group P/G.
        for (int k = 0; k < SG; k++) begin
          r = cla4(a_q[s-1][((s-1)*SG+k)*4 +: 4], b_q[s-1][((s-1)*SG+k)*4 +: 4], c);
          s_d[s][((s-1)*SG+k)*4 +: 4] = r[3:0];
          p_d[s][(s-1)*SG+k]          = r[4];
          g_d[s][(s-1)*SG+k]          = r[5];
          if (((s-1)*SG+k) == NG-1) cm_d[s] = r[6];
          c = r[5] | (r[4] & c);
        end
        c_d[s] = c;
      end
    end
  end

  // Output register only loads data for real beats so idle outputs keep the last result.
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    pg_d        = pg_q;
    gg_d        = gg_q;
    if (en) begin
      out_valid_d = valid_q[STAGES];
      if (valid_q[STAGES]) begin
        sum_d  = s_q[STAGES];
        cout_d = c_q[STAGES];
        ovf_d  = cm_q[STAGES] ^ c_q[STAGES];
        pg_d   = p_q[STAGES];
        gg_d   = g_q[STAGES];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s <= STAGES; s++) begin
        valid_q[s] <= 1'b0;
        a_q[s]     <= '0;
        b_q[s]     <= '0;
        s_q[s]     <= '0;
        p_q[s]     <= '0;
        g_q[s]     <= '0;
        c_q[s]     <= 1'b0;
        cm_q[s]    <= 1'b0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      pg_q        <= '0;
      gg_q        <= '0;
    end else begin
      for (int s = 0; s <= STAGES; s++) begin
        valid_q[s] <= valid_d[s];
        a_q[s]     <= a_d[s];
        b_q[s]     <= b_d[s];
        s_q[s]     <= s_d[s];
        p_q[s]     <= p_d[s];
        g_q[s]     <= g_d[s];
        c_q[s]     <= c_d[s];
        cm_q[s]    <= cm_d[s];
      end
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      pg_q        <= pg_d;
      gg_q        <= gg_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign P         = pg_q;
  assign G         = gg_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder (WIDTH=32, STAGES=2)
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic [7:0]  P;
  logic [7:0]  G;
  logic [49:0] got;

  int total = 0;
  int bad   = 0;

  cla_pipe_adder #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .P(P), .G(G)
  );

  always #5 clk = ~clk;

  assign got = {ovf, cout, G, P, sum};

  // Reference: {ovf, cout, G, P, sum} from plain arithmetic.
  function automatic logic [49:0] ref_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic ci, input logic sb);
    logic [31:0] bb;
    logic [32:0] full;
    logic [7:0]  pp;
    logic [7:0]  gg;
    logic        c0;
    logic        ov;
    bb   = sb ? ~b : b;
    c0   = sb ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, bb} + {32'b0, c0};
    ov   = (a[31] == bb[31]) && (full[31] != a[31]);
    for (int k = 0; k < 8; k++) begin
      pp[k] = ((a[k*4 +: 4] ^ bb[k*4 +: 4]) == 4'hF);
      gg[k] = (({1'b0, a[k*4 +: 4]} + {1'b0, bb[k*4 +: 4]}) > 5'd15);
    end
    return {ov, full[32], gg, pp, full[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
    in_valid = 1'b1;
    in1 = a;
    in2 = b;
    cin = ci;
    sub = sb;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    step();
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++;
    if (got !== 50'h0) begin bad++; $display("FAIL reset_data: got %h want 0", got); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_no_beat: got %b want 0", out_valid); end
    end
  endtask

  task automatic test_carry_ripple();
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early1: got %b want 0", out_valid); end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early2: got %b want 0", out_valid); end
    step();
    total++;
    if ({out_valid, got} !== {1'b1, 1'b0, 1'b1, 8'h01, 8'hFE, 32'h0}) begin
      bad++; $display("FAIL carry_ripple: got %b_%h want 1_%h", out_valid, got, {1'b0, 1'b1, 8'h01, 8'hFE, 32'h0});
    end
    step();
  endtask

  task automatic test_overflow_sub();
    drive(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    step();
    drive(32'h5, 32'h7, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    step();
    total++;
    if ({out_valid, ovf, cout, sum} !== {1'b1, 1'b1, 1'b0, 32'h8000_0000}) begin
      bad++; $display("FAIL signed_ovf: got v=%b ovf=%b cout=%b sum=%h want v=1 ovf=1 cout=0 sum=80000000",
                      out_valid, ovf, cout, sum);
    end
    step();
    total++;
    if ({out_valid, ovf, cout, sum} !== {1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE}) begin
      bad++; $display("FAIL subtract: got v=%b ovf=%b cout=%b sum=%h want v=1 ovf=0 cout=0 sum=fffffffe",
                      out_valid, ovf, cout, sum);
    end
    step();
  endtask

  task automatic test_group_pg();
    drive(32'hF, 32'h0, 1'b0, 1'b0);
    step();
    drive(32'hF, 32'hF, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    step();
    total++;
    if ({out_valid, P, G} !== {1'b1, 8'h01, 8'h00}) begin
      bad++; $display("FAIL group_pg1: got v=%b P=%h G=%h want v=1 P=01 G=00", out_valid, P, G);
    end
    step();
    total++;
    if ({out_valid, P, G, sum} !== {1'b1, 8'h00, 8'h01, 32'h1E}) begin
      bad++; $display("FAIL group_pg2: got v=%b P=%h G=%h sum=%h want v=1 P=00 G=01 sum=1e", out_valid, P, G, sum);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] got_q[$];
    logic [49:0] held;
    int          sent;
    int          stall_left;
    bit          stalled_once;
    sent = 0;
    stall_left = 0;
    stalled_once = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (out_valid && !stalled_once) begin
        stalled_once = 1'b1;
        stall_left = 2;
        held = got;
      end
      out_ready = (stall_left == 0);
      in_valid = (sent < 4);
      if (sent < 4) begin
        in1 = 32'(sent + 1);
        in2 = 32'h10;
        cin = 1'b0;
        sub = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || got !== held) begin
          bad++; $display("FAIL stall_hold: got rdy=%b v=%b data=%h want rdy=0 v=1 data=%h",
                          in_ready, out_valid, got, held);
        end
      end
      if (out_valid && out_ready) got_q.push_back(sum);
      if (in_valid && in_ready) sent++;
      step();
      if (stall_left > 0) stall_left--;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (!stalled_once) begin bad++; $display("FAIL stall_seen: got 0 want 1"); end
    total++;
    if (got_q.size() != 4) begin
      bad++; $display("FAIL bp_count: got %0d want 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_q[i] !== 32'(32'h11 + i)) begin
          bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], 32'(32'h11 + i));
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    drive(32'h1, 32'h2, 1'b0, 1'b0);
    step();
    drive(32'h3, 32'h4, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    drive(32'h5, 32'h6, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    in_valid = 1'b0;
    total++;
    if ({out_valid, got} !== 51'h0) begin
      bad++; $display("FAIL midflight_reset: got v=%b data=%h want v=0 data=0", out_valid, got);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midflight_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midflight_ghost[%0d]: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_full_throughput();
    logic [49:0] exp_q[$];
    logic [49:0] e;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sb;
    logic        exp_valid;
    out_ready = 1'b1;
    for (int k = 0; k <= 1005; k++) begin
      exp_valid = (k >= 4) && (k < 1004);
      total++;
      if (out_valid !== exp_valid) begin
        bad++; $display("FAIL thru_valid[%0d]: got %b want %b", k, out_valid, exp_valid);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL thru_extra[%0d]: got beat %h want none", k, got);
        end else begin
          e = exp_q.pop_front();
          total++;
          if (got !== e) begin bad++; $display("FAIL thru_data[%0d]: got %h want %h", k, got, e); end
        end
      end
      if (k < 1000) begin
        a  = $urandom;
        b  = $urandom;
        ci = 1'($urandom_range(1, 0));
        sb = 1'($urandom_range(1, 0));
        drive(a, b, ci, sb);
        exp_q.push_back(ref_calc(a, b, ci, sb));
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL thru_lost: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_overflow_sub();
    test_group_pg();
    test_backpressure();
    test_reset_midflight();
    test_full_throughput();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor, the next generation of our registered 16-bit CLA wrapper. The word is split into `STAGES` equal slices, one slice per pipeline stage, built from 4-bit CLA groups. The carry between slices is registered. A valid/ready handshake with full-pipeline stall lets the block sit between streaming producers and consumers in the datapath.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. Must be a multiple of `4*STAGES`.
- `STAGES`, default 2: number of arithmetic pipeline stages, from 1 to `WIDTH/4`. Each stage computes `WIDTH/STAGES` bits.

Ports:
- `clk`, input, 1: rising-edge clock. Single clock domain.
- `rst`, input, 1: reset. Synchronous, active-low.
- `in_valid`, input, 1: operand beat valid.
- `in_ready`, output, 1: block can accept a beat this cycle.
- `in1`, input, WIDTH: operand A.
- `in2`, input, WIDTH: operand B.
- `cin`, input, 1: carry-in. Ignored when `sub`=1.
- `sub`, input, 1: 0 selects A+B+cin; 1 selects A−B.
- `out_valid`, output, 1: result beat valid.
- `out_ready`, input, 1: consumer accepts the result.
- `sum`, output, WIDTH: result, modulo 2^WIDTH.
- `cout`, output, 1: carry out of the MSB. In subtract mode this is the inverted borrow (1 means A ≥ B, unsigned).
- `ovf`, output, 1: signed overflow, defined as carry into the MSB XOR carry out of the MSB.
- `P`, output, WIDTH/4: group propagate, one bit per 4-bit group.
- `G`, output, WIDTH/4: group generate, one bit per 4-bit group.

## Operation

**Effective operands**
- a = `in1`.
- b = `in2` XOR {WIDTH{`sub`}}.
- c0 = `sub` ? 1 : `cin`.

**Per-bit and per-group signals**
- Bit level: p_i = a_i ^ b_i, g_i = a_i & b_i.
- `P[k]` is the AND of p over bits 4k..4k+3.
- `G[k]` is the standard 4-bit lookahead generate of group k.

**Pipeline structure**
- Stage 0 is the input register: it captures a, b, c0 and `sub`.
- Stage s (1..`STAGES`) computes slice s−1 (its LSB slice first) using the carry registered by stage s−1.
- Slices not yet computed are carried forward as delayed operand bits.
- Slices already computed are carried forward as delayed sum, P and G bits.

**Handshake and stall**
- Global enable: `en` = !`out_valid` | `out_ready`. The pipeline moves only when `en`=1.
- `in_ready` = `en`.
- A beat is accepted when `in_valid` & `in_ready`.
- When `en`=1 and no beat is accepted, a bubble enters stage 0 with valid=0. Bubbles are not compressed.
- When `en`=0, every stage register (data and valid) holds its value. `sum`, `cout`, `ovf`, `P` and `G` stay stable while `out_valid`=1 and `out_ready`=0.
- Results leave in acceptance order. No beat is dropped or duplicated.

**Output gating**
- Data outputs are qualified by `out_valid` only.
- Their values while `out_valid`=0 are the last registered values, except immediately after reset.

## Timing

- Latency is `STAGES`+1 rising edges. A beat accepted at edge N appears with `out_valid`=1 after edge N+`STAGES`+1, provided no stall occurs.
- Each cycle of `en`=0 adds one cycle of latency.
- Throughput is one beat per cycle while `out_ready`=1.
- Reset: on any edge with `rst`=0, all valid bits clear. `sum`, `cout`, `ovf`, `P`, `G` and all internal registers go to 0.
- During reset, `in_ready` = 1 because `out_valid`=0.
- Reset mid-operation: all in-flight beats are discarded and none emerge afterward.
- A beat offered on the same edge that reset is asserted is not accepted.
- Wrap-around: the sum is truncated to WIDTH bits, and `cout` reports the lost carry.
- Simultaneous output pop and input accept in the same cycle is legal and required for full throughput.
- `in1`, `in2`, `cin` and `sub` are sampled only on accepting edges. Values at other times have no effect.

## Test plan

All scenarios use WIDTH=32, STAGES=2, latency 3.

1. **Carry ripple across the slice boundary.** Apply A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0. Required 3 edges after acceptance: sum=0x00000000, cout=1, ovf=0, P=0xFE, G=0x01.
2. **Signed overflow, then subtraction.** Apply A=0x7FFFFFFF, B=1, followed by A=5, B=7, sub=1 (cin=1 but ignored). Required: sum=0x80000000, cout=0, ovf=1, then sum=0xFFFFFFFE, cout=0, ovf=0.
3. **Backpressure.** Stream 4 back-to-back beats A=i, B=0x10 (i=1..4), holding `out_ready`=0 for 2 cycles after the first result. Required: `in_ready` drops while stalled; outputs hold stable; results are 0x11, 0x12, 0x13, 0x14 in order, with none lost or duplicated.
4. **Reset mid-flight.** Accept 2 beats, then drive `rst`=0 for 1 cycle before either emerges. Required: all outputs 0 and `out_valid`=0 after the reset edge; no result from either beat ever appears; `in_ready`=1.
5. **Group P/G.** Apply A=0x0000000F, B=0x00000000, then A=0x0000000F, B=0x0000000F. Required: P=0x01, G=0x00, then P=0x00, G=0x01, sum=0x1E.
6. **Full throughput.** Drive 1000 random beats with random add/sub and `in_valid`/`out_ready` both held at 1. Required: one result per cycle after a 3-cycle fill, every result matching a reference model bit-exactly.
